// File: rtl/sipo_deserializer_if.sv
// Handshake and data bundle between a serial source / parallel sink and the SIPO deserializer.
// master = the environment that drives bits and acknowledges words; slave = the deserializer.
interface sipo_deserializer_if #(
    parameter int WIDTH = 4
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clr;
    logic             sin;
    logic             sin_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             busy;
    logic [CNT_W-1:0] bit_cnt;
    logic             overrun;

    modport master (
        output clr, sin, sin_valid, out_ready,
        input  q, q_valid, busy, bit_cnt, overrun
    );

    modport slave (
        input  clr, sin, sin_valid, out_ready,
        output q, q_valid, busy, bit_cnt, overrun
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer: collects WIDTH qualified bits into a word and
// presents it on q with a valid/ready handshake; a word completing while q is still held is dropped.
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    sipo_deserializer_if.slave    bus
);
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_shift, w_shift_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_q_valid, w_q_valid_nxt;
    logic             r_overrun, w_overrun_nxt;
    logic [WIDTH-1:0] w_shifted;
    logic             w_complete;

    assign w_shifted  = MSB_FIRST ? {r_shift[WIDTH-2:0], bus.sin}
                                  : {bus.sin, r_shift[WIDTH-1:1]};
    assign w_complete = !bus.clr && bus.sin_valid && (r_cnt == LAST_CNT);

    // NOTE: every output of this block is given a hold value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_cnt_nxt     = r_cnt;
        w_q_nxt       = r_q;
        w_q_valid_nxt = r_q_valid;
        w_overrun_nxt = r_overrun;

        // The consumer handshake is independent of clr; a completion below may re-assert valid.
        if (r_q_valid && bus.out_ready) begin
            w_q_valid_nxt = 1'b0;
        end

        if (bus.clr) begin
            w_shift_nxt   = '0;
            w_cnt_nxt     = '0;
            w_state_nxt   = IDLE;
            w_overrun_nxt = 1'b0;
        end else if (bus.sin_valid) begin
            if (w_complete) begin
                w_shift_nxt = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
                if (!r_q_valid || bus.out_ready) begin
                    w_q_nxt       = w_shifted;
                    w_q_valid_nxt = 1'b1;
                end else begin
                    w_overrun_nxt = 1'b1;
                end
            end else begin
                w_shift_nxt = w_shifted;
                w_cnt_nxt   = r_cnt + CNT_W'(1);
                w_state_nxt = SHIFT;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_cnt     <= w_cnt_nxt;
            r_q       <= w_q_nxt;
            r_q_valid <= w_q_valid_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    assign bus.q       = r_q;
    assign bus.q_valid = r_q_valid;
    assign bus.busy    = (r_state == SHIFT);
    assign bus.bit_cnt = r_cnt;
    assign bus.overrun = r_overrun;
endmodule
